// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency mult/div with HI/LO commit,
// direct HI/LO writes, and a pipeline stall for dependent D-stage MD instructions.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        d_is_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [31:0] phi_reg;
    logic [31:0] plo_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        dz_reg;

    logic        op_mult;
    logic        op_div;
    logic        div_zero;
    logic        div_ovf;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic signed [31:0] a_s;
    logic signed [31:0] d_s;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0] d_u;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign op_mult  = (md_op == 3'd1) || (md_op == 3'd2);
    assign op_div   = (md_op == 3'd3) || (md_op == 3'd4);
    assign div_zero = (B == 32'd0);
    assign div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // A zero divisor is replaced by 1 so the dividers never see x/0; the
    // result is discarded at commit anyway.
    assign a_s    = $signed(A);
    assign d_s    = div_zero ? 32'sd1 : $signed(B);
    assign d_u    = div_zero ? 32'd1 : B;
    assign quot_s = div_ovf ? 32'sh8000_0000 : a_s / d_s;
    assign rem_s  = div_ovf ? 32'sd0 : a_s % d_s;
    assign quot_u = A / d_u;
    assign rem_u  = A % d_u;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (md_op)
            3'd1: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            3'd2: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            3'd3: begin res_hi = rem_s;         res_lo = quot_s;       end
            3'd4: begin res_hi = rem_u;         res_lo = quot_u;       end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            phi_reg   <= 32'd0;
            plo_reg   <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            dz_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (op_mult || op_div) begin
                            phi_reg   <= res_hi;
                            plo_reg   <= res_lo;
                            cnt_reg   <= op_mult ? MULT_CNT : DIV_CNT;
                            dz_reg    <= op_div && div_zero;
                            state_reg <= BUSY;
                        end else if (md_op == 3'd5) begin
                            hi_reg <= A;
                        end else if (md_op == 3'd6) begin
                            lo_reg <= A;
                        end
                    end
                end
                BUSY: begin
                    // Any start seen here is dropped on purpose.
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg <= IDLE;
                        if (!dz_reg) begin
                            hi_reg <= phi_reg;
                            lo_reg <= plo_reg;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign hi    = hi_reg;
    assign lo    = lo_reg;
    assign busy  = (state_reg == BUSY);
    assign stall = d_is_md & (busy | (start & (op_mult | op_div)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized ops
// against an arithmetic reference model of HI/LO and busy latency.
module tb_mdu_ctrl;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        d_is_md = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .A(A), .B(B), .d_is_md(d_is_md),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: architectural effect of one accepted instruction.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        case (op)
            3'd1: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            3'd2: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            3'd3: if (b != 32'd0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q = sa / sb;
                r = sa % sb;
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            3'd4: if (b != 32'd0) begin
                m_lo = a / b; m_hi = a % b;
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    function automatic int model_cycles(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return MULT_CYCLES;
        if (op == 3'd3 || op == 3'd4) return DIV_CYCLES;
        return 0;
    endfunction

    // Called at a falling edge; returns at the falling edge where busy is low.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic dmd, input int inject_at, input string name);
        logic [31:0] old_hi, old_lo;
        logic arith;
        int exp_cyc, cnt;
        old_hi  = m_hi;
        old_lo  = m_lo;
        arith   = (op >= 3'd1 && op <= 3'd4);
        exp_cyc = model_cycles(op);
        start = 1'b1; md_op = op; A = a; B = b; d_is_md = dmd;
        #1;
        checks++;
        if (stall !== (dmd & arith)) begin
            errors++;
            $display("FAIL %s start_stall: got %b expected %b", name, stall, dmd & arith);
        end
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        model_apply(op, a, b);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            checks++;
            if (stall !== dmd) begin
                errors++;
                $display("FAIL %s busy_stall: got %b expected %b", name, stall, dmd);
            end
            checks++;
            if (hi !== old_hi || lo !== old_lo) begin
                errors++;
                $display("FAIL %s early_commit: got hi=%h lo=%h expected hi=%h lo=%h",
                         name, hi, lo, old_hi, old_lo);
            end
            cnt++;
            if (cnt == inject_at) begin
                start = 1'b1; md_op = 3'($urandom_range(1, 4));
                A = $urandom; B = $urandom;
            end
            @(negedge clk);
            start = 1'b0; md_op = 3'd0;
        end
        checks++;
        if (cnt != exp_cyc) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, cnt, exp_cyc);
        end
        checks++;
        if (hi !== m_hi || lo !== m_lo) begin
            errors++;
            $display("FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h",
                     name, hi, lo, m_hi, m_lo);
        end
        $display("op %s md_op=%0d A=%h B=%h -> hi=%h lo=%h busy_cycles=%0d", name, op, a, b, hi, lo, cnt);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b expected 0 0 0", hi, lo, busy);
        end
        start = 1'b1; md_op = 3'd1; d_is_md = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall_arith: got %b expected 1", stall);
        end
        md_op = 3'd5;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall_mthi: got %b expected 0", stall);
        end
        start = 1'b0; md_op = 3'd0; d_is_md = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        $display("reset released");
    endtask

    task automatic test_mult();
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 0, "mult_directed");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, 0, "multu_directed");
        for (int i = 0; i < 4; i++)
            run_op(3'($urandom_range(1, 2)), $urandom, $urandom, 1'($urandom_range(0, 1)), 0, "mult_rand");
    endtask

    task automatic test_div();
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 4, "div_neg_ignore_start");
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "div_overflow");
        run_op(3'd3, 32'd7, 32'hFFFF_FFFE, 1'b1, 0, "div_pos_neg");
        for (int i = 0; i < 4; i++)
            run_op(3'($urandom_range(3, 4)), $urandom, $urandom_range(1, 1000), 1'b1, 0, "div_rand");
    endtask

    task automatic test_div_zero();
        run_op(3'd5, 32'h11, 32'd0, 1'b1, 0, "mthi_setup");
        run_op(3'd6, 32'h22, 32'd0, 1'b1, 0, "mtlo_setup");
        run_op(3'd4, 32'd100, 32'd0, 1'b1, 0, "divu_by_zero");
        run_op(3'd3, 32'h8765_4321, 32'd0, 1'b0, 0, "div_by_zero");
    endtask

    task automatic test_moves_and_none();
        run_op(3'd6, 32'h1234, 32'd0, 1'b1, 0, "mtlo_directed");
        run_op(3'd5, $urandom, 32'd0, 1'b1, 0, "mthi_rand");
        run_op(3'd0, $urandom, $urandom, 1'b1, 0, "op_none");
        run_op(3'd7, $urandom, $urandom, 1'b1, 0, "op_reserved");
    endtask

    task automatic test_reset_mid_op();
        run_op(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, 0, "mthi_pre_abort");
        start = 1'b1; md_op = 3'd3; A = 32'd100; B = 32'd7; d_is_md = 1'b1;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL abort_reset: got busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL abort_stall: got %b expected 0", stall);
        end
        $display("reset asserted mid-divide: busy=%b hi=%h lo=%h", busy, hi, lo);
        @(negedge clk);
        reset = 1'b1;
        run_op(3'd4, 32'd9, 32'd4, 1'b1, 0, "divu_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [2:0] op;
        logic [31:0] b;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            run_op(op, $urandom, b, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, "rand");
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_moves_and_none();
        test_reset_mid_op();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5: number of busy cycles for mult/multu (legal range 1-15).
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10: number of busy cycles for div/divu (legal range 1-15).
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: E-stage MD instruction valid, one cycle per instruction.
REQ-006 The block SHALL have port md_op, input, 3 bits: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-007 The block SHALL have port A, input, 32 bits: E-stage GPR[rs] operand.
REQ-008 The block SHALL have port B, input, 32 bits: E-stage GPR[rt] operand.
REQ-009 The block SHALL have port d_is_md, input, 1 bit: D-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
REQ-010 The block SHALL have port hi, output, 32 bits: architectural HI register.
REQ-011 The block SHALL have port lo, output, 32 bits: architectural LO register.
REQ-012 The block SHALL have port busy, output, 1 bit: a multiply or divide is in progress.
REQ-013 The block SHALL have port stall, output, 1 bit: freeze PC/F/D and insert bubble into E.

Function
REQ-014 The block SHALL implement a two-state FSM, IDLE and BUSY, plus a 4-bit down-counter cnt and 32-bit pending registers phi/plo.
REQ-015 In IDLE, at a rising edge with start=1 and md_op in {1,2,3,4}, the block SHALL compute the result from A/B, store it in phi/plo, load cnt with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4), and enter BUSY.
REQ-016 mult SHALL produce the signed 64-bit A*B, and multu the unsigned 64-bit A*B, with {phi,plo} = product.
REQ-017 div/divu SHALL put the quotient (truncated toward zero) in plo and the remainder (sign of dividend for div) in phi.
REQ-018 For div with 0x80000000 / 0xFFFFFFFF, the block SHALL set plo=0x80000000 and phi=0.
REQ-019 When B=0 for div/divu, the block SHALL run the full DIV_CYCLES and leave hi/lo unchanged at commit.
REQ-020 busy SHALL equal (state==BUSY), i.e. be high for exactly MULT_CYCLES/DIV_CYCLES cycles after the start edge.
REQ-021 In BUSY, cnt SHALL decrement each edge; at the edge where cnt==1 the block SHALL write hi<=phi and lo<=plo (unless divide-by-zero) and return to IDLE.
REQ-022 The new hi/lo values SHALL be visible in the same cycle busy falls.
REQ-023 In IDLE, at an edge with start=1 and md_op=5, hi<=A; with md_op=6, lo<=A; neither SHALL cause busy.
REQ-024 start while in BUSY SHALL be ignored: no state, counter or hi/lo change.
REQ-025 stall SHALL be combinational: stall = d_is_md & (busy | (start & md_op in {1,2,3,4})).
REQ-026 stall SHALL therefore be high from the start cycle through the last busy cycle when d_is_md=1.
REQ-027 start with md_op in {0,7} SHALL have no effect.

Reset
REQ-028 reset=0 SHALL immediately, independent of clk, force state=IDLE, cnt=0, hi=0, lo=0, phi=0, plo=0 and busy=0.
REQ-029 stall SHALL follow d_is_md & start-term combinationally during reset.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no hi/lo commit.
REQ-031 The block SHALL accept start on the first rising edge after reset deasserts.

Verification
REQ-032 mult A=0xFFFFFFFF, B=2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-033 multu A=0xFFFFFFFF, B=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-034 div A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; a second start at busy cycle 4 is ignored.
REQ-035 divu A=100, B=0 with prior hi=0x11, lo=0x22 -> busy 10 cycles, then hi=0x11, lo=0x22 unchanged.
REQ-036 mtlo A=0x1234 while d_is_md=1 -> lo=0x1234 next edge, busy=0 and stall=0 throughout.
REQ-037 div started, reset pulled low at busy cycle 3 -> busy=0, hi=lo=0 immediately; divu 9/4 issued after release -> lo=2, hi=1.
